// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2D convolution engine.
// The output-shaping rules (ReLU, then saturate or truncate) live here.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Products are DW+CW wide, so K*K of them summed cannot overflow this width.
  function automatic int acc_width(input int dw, input int cw, input int k);
    return dw + cw + clog2(k * k);
  endfunction

  // ReLU first, then clamp to the signed ow-bit range. The caller keeps the low ow bits,
  // so with sat_en=0 the result is a plain truncation.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] sum,
                                                  input int ow,
                                                  input bit sat_en,
                                                  input bit relu_en);
    logic signed [63:0] v, hi, lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    v  = sum;
    if (relu_en && v < 0) v = '0;
    if (sat_en) begin
      if (v > hi)      v = hi;
      else if (v < lo) v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Chain of TAPS row buffers, each DEPTH pixels deep. Tap j returns the
// pixel from exactly j+1 rows before the one currently being written.
module conv_line_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int TAPS  = 2
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [DW-1:0]            din,
  output logic [TAPS-1:0][DW-1:0]  taps
);

  logic [DW-1:0] mem [DEPTH*TAPS];

  // NOTE: storage has no reset; its contents are never used before rows are refilled,
  // and leaving it out lets synthesis map it to plain flops or SRLs.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH*TAPS; i++) mem[i] <= mem[i-1];
    end
  end

  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    assign taps[j] = mem[(j+1)*DEPTH-1];
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK "valid" 2D convolution: raster pixels in, raster results out,
// two-stage multiply/accumulate pipeline that stalls as a whole on backpressure.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int DW      = 8,
  parameter int CW      = 8,
  parameter int OW      = 16,
  parameter bit SAT_EN  = 1'b1,
  parameter bit RELU_EN = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coeff_we,
  input  logic [clog2(K*K)-1:0]       coeff_addr,
  input  logic signed [CW-1:0]        coeff_data,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DW-1:0]        in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OW-1:0]        out_data,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int N    = K * K;
  localparam int AIW  = clog2(N);
  localparam int PW   = DW + CW;
  localparam int AW   = acc_width(DW, CW, K);
  localparam int COLW = clog2(IMG_W);
  localparam int ROWW = clog2(IMG_H);
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_W - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_H - 1);
  localparam logic [COLW-1:0] COL_K1   = COLW'(K - 1);
  localparam logic [ROWW-1:0] ROW_K1   = ROWW'(K - 1);

  state_t               state;
  logic [COLW-1:0]      col;
  logic [ROWW-1:0]      row;
  logic signed [CW-1:0] kernel   [N];
  logic signed [DW-1:0] win      [N];
  logic signed [DW-1:0] win_next [N];
  logic [K-2:0][DW-1:0] taps;
  logic signed [PW-1:0] prod     [N];
  logic signed [AW-1:0] sum;
  logic                 p_valid;
  logic                 adv, accept, win_ok, last_pix;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = (state == RUN) && adv;
  assign accept   = in_valid && in_ready;
  assign win_ok   = (row >= ROW_K1) && (col >= COL_K1);
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  conv_line_buffer #(.DEPTH(IMG_W), .DW(DW), .TAPS(K-1)) u_line_buffer (
    .clk  (clk),
    .en   (accept),
    .din  (in_data),
    .taps (taps)
  );

  // Window row 0 is the oldest image row, column K-1 the newest pixel; index is row-major
  // so it lines up with the coefficient addressing.
  // NOTE: every element is assigned on every pass, so no latch can be inferred.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++)
        win_next[r*K+c] = win[r*K+c+1];
    for (int r = 0; r < K-1; r++)
      win_next[r*K+K-1] = taps[K-2-r];
    win_next[N-1] = in_data;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + AW'(prod[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < N; i++) win[i] <= win_next[i];
  end

  // Products are taken from the next window so a result appears two cycles after its pixel.
  always_ff @(posedge clk) begin
    if (adv && accept && win_ok)
      for (int i = 0; i < N; i++) prod[i] <= PW'(win_next[i]) * PW'(kernel[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) kernel[i] <= '0;
    end else if (coeff_we && state == IDLE) begin
      for (int i = 0; i < N; i++)
        if (coeff_addr == AIW'(i)) kernel[i] <= coeff_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      p_valid   <= accept && win_ok;
      out_valid <= p_valid;
      if (p_valid) out_data <= OW'(sat_relu(64'(sum), OW, SAT_EN, RELU_EN));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state <= RUN;
          row   <= '0;
          col   <= '0;
          busy  <= 1'b1;
        end
        RUN: if (accept) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROWW'(1);
          end else begin
            col <= col + COLW'(1);
          end
          if (last_pix) state <= DRAIN;
        end
        // The last pixel always completes a window, so an empty product stage means the
        // final result is in the output register or already gone.
        DRAIN: if (!p_valid && (!out_valid || out_ready)) begin
          state      <= DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule
